// File: rtl/pdm_demod.sv
// pdm_demod: recovers the programmed level from a 1-bit pulse-density stream.
//
// A 2-flop synchroniser brings pdm_in into the clk domain.  A non-overlapping
// boxcar integrator then counts ones over a frame of 2^WINDOW_LOG2 enabled
// cycles.  At each frame end the count is scaled to OUT_W bits, saturated, and
// presented with a one-cycle valid strobe.
//
// Ports:
//   clk          - single clock, rising edge
//   reset_n      - asynchronous active-low reset
//   enable       - when low, frame phase, count and outputs hold (sync keeps running)
//   frame_sync   - synchronous frame restart, discards the partial count
//   pdm_in       - PDM bit stream, may be asynchronous to clk
//   sample_out   - value of the last completed frame, held between frames
//   sample_valid - one-cycle pulse when sample_out updates
//   changed      - one-cycle pulse with sample_valid when the new value differs

module pdm_demod #(
    parameter int unsigned WINDOW_LOG2 = 6,
    parameter int unsigned OUT_W       = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             frame_sync,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             changed
);

    localparam int unsigned Shift = WINDOW_LOG2 - OUT_W;

    logic                   s1_q, s2_q;
    logic [WINDOW_LOG2-1:0] phase_q, phase_d;
    logic [WINDOW_LOG2:0]   ones_q, ones_d;
    logic [OUT_W-1:0]       sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   changed_q, changed_d;

    logic [WINDOW_LOG2:0]   total;
    logic [WINDOW_LOG2:0]   scaled;
    logic [OUT_W-1:0]       sat_val;
    logic                   frame_end;

    assign total     = ones_q + {{WINDOW_LOG2{1'b0}}, s2_q};
    assign scaled    = total >> Shift;
    assign frame_end = (phase_q == {WINDOW_LOG2{1'b1}});

    // total never exceeds 2^WINDOW_LOG2, so after scaling only bit OUT_W can be
    // set above the output range, and only for an all-ones frame.
    assign sat_val = scaled[OUT_W] ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];

    // Upper bits of scaled are zero by construction.
    logic unused_scaled;
    assign unused_scaled = ^scaled;

    always_comb begin
        phase_d   = phase_q;
        ones_d    = ones_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        if (frame_sync) begin
            // Restart wins over a coincident frame end; no sample is emitted.
            phase_d = '0;
            ones_d  = '0;
        end else if (enable) begin
            if (frame_end) begin
                sample_d  = sat_val;
                valid_d   = 1'b1;
                changed_d = (sat_val != sample_q);
                ones_d    = '0;
                phase_d   = '0;
            end else begin
                ones_d  = total;
                phase_d = phase_q + WINDOW_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            phase_q   <= '0;
            ones_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= pdm_in;
            s2_q      <= s1_q;
            phase_q   <= phase_d;
            ones_q    <= ones_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign changed      = changed_q;

endmodule

// File: tb/tb_pdm_demod.sv
// Testbench for pdm_demod (default parameters: 64-cycle frame, 5-bit output).
// The stimulus process pushes the expected sample, changed flag and frame-end
// edge number into a queue; the monitor pops and compares on every valid pulse.

module tb_pdm_demod;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       frame_sync;
    logic       pdm_in;
    logic [4:0] sample_out;
    logic       sample_valid;
    logic       changed;

    pdm_demod #(
        .WINDOW_LOG2(6),
        .OUT_W      (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .frame_sync  (frame_sync),
        .pdm_in      (pdm_in),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .changed     (changed)
    );

    always #5 clk = ~clk;

    // Free-running edge counter; at a negedge it holds the number of the
    // rising edge just past.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int chg;
        int at_edge;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int val, input int chg, input int at_edge);
        exp_t e;
        e.val     = val;
        e.chg     = chg;
        e.at_edge = at_edge;
        q.push_back(e);
    endtask

    // Called at a negedge; inputs apply to the next n rising edges.
    task automatic drive(input logic en, input logic fs, input logic b, input int n);
        enable     = en;
        frame_sync = fs;
        pdm_in     = b;
        repeat (n) @(negedge clk);
    endtask

    // First-order sigma-delta bit pattern: exactly 2*lvl ones per 64 bits.
    function automatic logic lvl_bit(input int lvl, input int i);
        return ((((i + 1) * 2 * lvl) / 64) - ((i * 2 * lvl) / 64)) != 0;
    endfunction

    // Two disabled pre-roll cycles load the synchroniser so the first enabled
    // edge counts pattern bit 0; then two full frames of the pattern.
    task automatic run_level(input int lvl, input int chg_first);
        int t;
        drive(1'b0, 1'b0, lvl_bit(lvl, 0), 1);
        drive(1'b0, 1'b0, lvl_bit(lvl, 1), 1);
        t = cyc;
        push(lvl, chg_first, t + 64);
        push(lvl, 0, t + 128);
        for (int i = 0; i < 128; i++) drive(1'b1, 1'b0, lvl_bit(lvl, (i + 2) % 64), 1);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got sample %0d at edge %0d, expected none",
                             sample_out, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sample_out", int'(sample_out), e.val);
                    check("changed", int'(changed), e.chg);
                    check("valid_edge", cyc, e.at_edge);
                end
            end else if (changed) begin
                check("changed_without_valid", int'(changed), 0);
            end
        end
    end

    initial begin
        int t;
        reset_n    = 1'b0;
        enable     = 1'b0;
        frame_sync = 1'b0;
        pdm_in     = 1'b0;
        @(negedge clk);

        // Held in reset with pdm_in toggling: outputs stay 0.
        for (int i = 0; i < 6; i++) begin
            pdm_in = ~pdm_in;
            enable = 1'b1;
            @(negedge clk);
            check("rst_sample", int'(sample_out), 0);
            check("rst_valid", int'(sample_valid), 0);
            check("rst_changed", int'(changed), 0);
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2);

        // Constant 0: three samples of 0, no change.
        t = cyc;
        push(0, 0, t + 64);
        push(0, 0, t + 128);
        push(0, 0, t + 192);
        drive(1'b1, 1'b0, 1'b0, 192);

        // Constant 1: 64 ones saturate to 31.
        drive(1'b0, 1'b0, 1'b1, 2);
        t = cyc;
        push(31, 1, t + 64);
        push(31, 0, t + 128);
        drive(1'b1, 1'b0, 1'b1, 128);

        // Generator loopback levels.
        run_level(8, 1);
        run_level(26, 1);

        // frame_sync at phase 40 of an all-ones frame.
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b1, 40);
        drive(1'b1, 1'b1, 1'b1, 1);
        t = cyc;
        push(31, 1, t + 64);
        drive(1'b1, 1'b0, 1'b1, 64);
        // frame_sync coincident with phase 63: no pulse.
        drive(1'b1, 1'b0, 1'b1, 63);
        drive(1'b1, 1'b1, 1'b1, 1);
        t = cyc;
        push(31, 0, t + 64);
        drive(1'b1, 1'b0, 1'b1, 64);

        // Reset mid-frame with ones=20.
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b1, 20);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_sample", int'(sample_out), 0);
        check("midrst_valid", int'(sample_valid), 0);
        check("midrst_changed", int'(changed), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pdm_in = ~pdm_in;
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Post-release: 20 counted ones -> 10.
        drive(1'b0, 1'b0, 1'b1, 2);
        t = cyc;
        push(10, 1, t + 64);
        drive(1'b1, 1'b0, 1'b1, 18);
        drive(1'b1, 1'b0, 1'b0, 46);

        // 10-cycle enable gap; ones arrive at the integrator only in the gap.
        drive(1'b0, 1'b0, 1'b0, 2);
        t = cyc;
        push(0, 1, t + 74);
        drive(1'b1, 1'b0, 1'b0, 18);
        drive(1'b1, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 1'b0, 44);

        drive(1'b0, 1'b0, 1'b0, 5);
        check("pending_expected", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pdm_demod.md
# pdm_demod

Downstream companion to the 5-bit PDM generator: recovers the programmed level from its 1-bit pulse-density stream. A 2-flop input synchroniser feeds a non-overlapping boxcar integrator over a fixed 2^WINDOW_LOG2-cycle frame; the per-frame ones count is scaled to OUT_W bits and presented with a one-cycle valid strobe. Used on-chip for loopback self-test of the generator and off-chip as the receive-side decoder.

## Interface

- WINDOW_LOG2, 6, log2 of frame length in clocks (64 by default); legal 3..10.
- OUT_W, 5, output sample width; must satisfy 1 <= OUT_W <= WINDOW_LOG2.
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- enable  input  1  when low, synchroniser keeps running; frame phase, ones counter and outputs hold.
- frame_sync  input  1  synchronous restart of the frame; discards the partial count.
- pdm_in  input  1  PDM bit stream; asynchronous to clk allowed.
- sample_out  output  OUT_W  last completed frame value, held between frames.
- sample_valid  output  1  one-cycle pulse when sample_out is updated.
- changed  output  1  one-cycle pulse, coincident with sample_valid, when the new sample differs from the previous sample_out.

## Operation

- Synchroniser: pdm_in -> s1 -> s2, always clocked, unaffected by enable; s2 is the integrated bit.
- State: phase (WINDOW_LOG2 bits), ones (WINDOW_LOG2+1 bits), sample_out, sample_valid, changed.
- With enable=1 and frame_sync=0, each cycle:
  - phase < 2^WINDOW_LOG2-1: ones <= ones + s2; phase <= phase+1.
  - phase == 2^WINDOW_LOG2-1 (frame end): total = ones + s2 (range 0..2^WINDOW_LOG2); scaled = total >> (WINDOW_LOG2-OUT_W); sample_out <= min(scaled, 2^OUT_W-1); sample_valid <= 1; changed <= (new value != old sample_out); ones <= 0; phase <= 0.
- Saturation: only total = 2^WINDOW_LOG2 (all ones) saturates; default maps 64 -> 31.
- frame_sync=1 (any enable): phase <= 0, ones <= 0, no sample emitted; it wins over a simultaneous frame end.
- enable=0 and frame_sync=0: phase, ones and sample_out hold; sample_valid and changed are 0.
- sample_valid and changed are 0 in every cycle without a frame-end update.
- reset_n low at any time, including mid-frame: s1, s2, phase, ones, sample_out, sample_valid and changed all clear to 0 immediately; the first frame starts at phase 0 on the first enabled edge after release.

## Timing

- Reset values: sample_out=0, sample_valid=0, changed=0.
- Input latency: a pdm_in level present before edge k is in s2 after edge k+1 and is counted at edge k+2.
- Frame: exactly 2^WINDOW_LOG2 enabled cycles of s2 per sample. sample_valid is high in the cycle after the frame-end edge. Period between valid pulses is 64 enabled cycles (default) with no gaps.
- Output latency from first bit of a frame at pdm_in to sample_valid: 2 + 64 cycles (default, continuous enable).
- No backpressure; a consumer must capture sample_out on sample_valid or before the next frame end.
- Disabled cycles stretch the frame; they neither count nor advance phase.

## Test plan

- Reset: hold reset_n=0 with pdm_in toggling -> all outputs 0; assert reset_n mid-frame with ones=20 -> outputs clear at once, and the next sample counts only post-release bits.
- Constant pdm_in=0 for 3 frames -> three sample_valid pulses 64 cycles apart, sample_out=0, changed=0 on all three.
- Constant pdm_in=1 -> sample_out=31 (saturated from 64), changed=1 on the first frame only.
- Generator loopback at level 5'h08 (16 ones per 64) then 5'h1a (52 ones) -> sample_out=8 then 26, changed=1 on each transition frame and 0 on repeats.
- frame_sync asserted at phase 40 of an all-ones frame -> no valid pulse at the old frame end; next valid pulse comes 64 cycles after sync with sample_out=31. Sync coincident with phase 63 -> no pulse.
- enable low for 10 cycles mid-frame with pdm_in=1 during the gap and 0 otherwise -> the gap bits are not counted (sample_out=0), and the valid pulse is delayed by exactly 10 cycles.
